plab5_mcore_net_msg_to_mem_req_buf: RTL and testbench
=====================================================

Name: plab5_mcore_net_msg_to_mem_req_buf

Overview:
- Bank-side receiver for the core-to-bank memory request network.
- Accepts split network request messages (control word plus data word), checks the requester-domain bit against the bank's domain policy, and strips the network header.
- Accepted requests go into a 2-entry buffer and leave as memory requests on a val/rdy port; rejected requests become a reject notification carrying the source and opaque for the error/response path.
- Sits between the bank's network output terminal and the bank cache or memory port.

Parameters:
- p_mem_opaque_nbits, 8, memory opaque width (mo)
- p_mem_addr_nbits, 32, memory address width (ma)
- p_mem_data_nbits, 32, memory data width (md)
- p_net_opaque_nbits, 4, network opaque width (no)
- p_net_srcdest_nbits, 3, network src/dest width (ns)
- p_bank_domain, 2, domain policy: 0 = accept domain 0 only, 1 = accept domain 1 only, 2 = accept both
- c_mem_msg_cnbits, derived, memory request control width = 3 + mo + ma + 2 (type, opaque, addr, len); 45 at defaults
- c_net_msg_cnbits, derived, ns + ns + no + c_mem_msg_cnbits + 1; 56 at defaults

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- net_req_val  in  1  network request valid
- net_req_rdy  out  1  network request ready
- net_msg_control  in  c_net_msg_cnbits  fields MSB to LSB: {dest, src, opaque, dom_n, mem_ctrl}
- net_msg_data  in  md  request data
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory request ready
- mem_req_msg  out  c_mem_msg_cnbits+md  {type, opaque, addr, len, data}; opaque passes through unchanged (its top ns bits hold src)
- mem_req_domain  out  1  requester domain of the head entry
- rej_val  out  1  reject notification valid
- rej_rdy  in  1  reject notification ready
- rej_src  out  ns  source of the rejected request
- rej_opaque  out  mo  memory opaque of the rejected request
- rej_count  out  8  saturating count of rejects

Behaviour:
- Decode: req_dom = ~dom_n.
  - accept = (p_bank_domain==2) || (req_dom == p_bank_domain[0]).
  - dest and the network opaque are ignored.
- Request FIFO: 2 entries, each holding {mem_ctrl, data, req_dom}; head pointer, tail pointer, count 0..2, 1-bit pointers that wrap.
- Reject register: 1 entry holding {src, mem opaque}.
- net_req_rdy = (count<2) && !rej_val, registered-free (combinational from state only, never from net_req_val).
  - A held reject therefore stalls all input. This preserves ordering and is intentional.
- Input fire = net_req_val && net_req_rdy:
  - accept=1: write the tail entry, tail++, count++.
  - accept=0: load the reject register, rej_val=1 next cycle, rej_count += 1, saturating at 255.
- Output:
  - mem_req_val = (count!=0); mem_req_msg and mem_req_domain are driven from the head entry.
  - Fire (mem_req_val && mem_req_rdy): head++, count--.
- Simultaneous input and output fire with count==1: count stays 1, and the head advances to the new entry.
  - With count==2, input is not ready, so no simultaneous fire is possible. There is no bypass path.
- Latency: a request accepted at edge N is visible on mem_req at cycle N+1. Throughput is 1 per cycle while mem_req_rdy stays high.
- Reject: rej_val clears on rej_val && rej_rdy. The next input fire is possible in that same cycle only if rdy is computed from the pre-clear state, i.e. not that cycle (rej_val is still high).
- Reset (asynchronous assert, any cycle, including mid-transfer): count=0, pointers=0, rej_val=0, rej_count=0, mem_req_val=0, net_req_rdy=1 at the first clock after deassert. Buffered entries are discarded.
- Outputs must not change while val is high and rdy is low.

Decomposition:
- Shared package / header:
  - network control field-range macros (dest, src, opaque, dom_n, payload)
  - memory request control field macros, reusing the existing VC_MEM_REQ_MSG_*_FIELD definitions
  - domain policy constants DOM_0, DOM_1, DOM_ANY
- One natural sub-module: plab5_mcore_req_queue2, a 2-entry val/rdy queue parameterised by width and instantiated for {mem_ctrl, data, req_dom}.
- Decode, reject register and counter stay in the top module.

Test Plan:
- Domain pass, p_bank_domain=2:
  - Stimulus: src=1, dom_n=0, type=read, opaque=0x25, addr=0x0000_4010, data=0xDEADBEEF.
  - Required: mem_req_val is 1 the next cycle; mem_req_msg carries opaque 0x25, addr 0x4010, data 0xDEADBEEF; mem_req_domain=1.
- Reject, p_bank_domain=0:
  - Stimulus: src=3, dom_n=0, opaque=0x61.
  - Required: rej_val=1, rej_src=3, rej_opaque=0x61, rej_count=1, mem_req_val stays 0, net_req_rdy=0 until rej_rdy=1.
- Backpressure:
  - Stimulus: mem_req_rdy=0, send 3 accepted requests A, B, C.
  - Required: net_req_rdy falls after B, C stalls. After mem_req_rdy=1, the output order is A, B, C on consecutive cycles.
- Streaming:
  - Stimulus: mem_req_rdy=1, 8 back-to-back requests with addr 0x0, 0x10, ..., 0x70.
  - Required: one memory request per cycle, same order, count never exceeds 1.
- Saturation:
  - Stimulus: 260 rejected requests, rej_rdy=1.
  - Required: rej_count holds at 255.
- Reset mid-operation:
  - Stimulus: assert reset with count=2 and rej_val=1.
  - Required: mem_req_val=0 and rej_val=0 immediately (asynchronously); after release, net_req_rdy=1 and no stale entry is emitted.

Source files
------------

// File: rtl/plab5_mcore_net_msg_to_mem_req_buf_pkg.sv
// Shared definitions for the bank-side network-to-memory request receiver:
// domain policy encodings, message widths and the domain accept rule.
package plab5_mcore_net_msg_to_mem_req_buf_pkg;

    typedef enum logic [1:0] {
        DOM_0   = 2'd0,
        DOM_1   = 2'd1,
        DOM_ANY = 2'd2
    } dom_policy_e;

    localparam int MEM_REQ_TYPE_NBITS = 3;
    localparam int MEM_REQ_LEN_NBITS  = 2;

    // Memory request control word: {type, opaque, addr, len}
    function automatic int mem_msg_cnbits(input int mo, input int ma);
        return MEM_REQ_TYPE_NBITS + mo + ma + MEM_REQ_LEN_NBITS;
    endfunction

    // Network control word: {dest, src, opaque, dom_n, mem_ctrl}
    function automatic int net_msg_cnbits(input int ns, input int no, input int mo, input int ma);
        return ns + ns + no + mem_msg_cnbits(mo, ma) + 1;
    endfunction

    function automatic logic domain_accept(input int policy, input logic req_dom);
        if (policy == int'(DOM_ANY)) begin
            return 1'b1;
        end
        return req_dom == policy[0];
    endfunction

endpackage

// File: rtl/plab5_mcore_net_msg_to_mem_req_buf_if.sv
// Bank-side bundle: network request input, memory request output and the
// reject notification channel.
interface plab5_mcore_net_msg_to_mem_req_buf_if
    import plab5_mcore_net_msg_to_mem_req_buf_pkg::*;
#(
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3
);
    localparam int c_mem_msg_cnbits = mem_msg_cnbits(p_mem_opaque_nbits, p_mem_addr_nbits);
    localparam int c_net_msg_cnbits = net_msg_cnbits(p_net_srcdest_nbits, p_net_opaque_nbits,
                                                     p_mem_opaque_nbits, p_mem_addr_nbits);

    logic                                       net_req_val;
    logic                                       net_req_rdy;
    logic [c_net_msg_cnbits-1:0]                net_msg_control;
    logic [p_mem_data_nbits-1:0]                net_msg_data;
    logic                                       mem_req_val;
    logic                                       mem_req_rdy;
    logic [c_mem_msg_cnbits+p_mem_data_nbits-1:0] mem_req_msg;
    logic                                       mem_req_domain;
    logic                                       rej_val;
    logic                                       rej_rdy;
    logic [p_net_srcdest_nbits-1:0]             rej_src;
    logic [p_mem_opaque_nbits-1:0]              rej_opaque;
    logic [7:0]                                 rej_count;

    modport slave (
        input  net_req_val, net_msg_control, net_msg_data, mem_req_rdy, rej_rdy,
        output net_req_rdy, mem_req_val, mem_req_msg, mem_req_domain,
               rej_val, rej_src, rej_opaque, rej_count
    );

    modport master (
        output net_req_val, net_msg_control, net_msg_data, mem_req_rdy, rej_rdy,
        input  net_req_rdy, mem_req_val, mem_req_msg, mem_req_domain,
               rej_val, rej_src, rej_opaque, rej_count
    );

endinterface

// File: rtl/plab5_mcore_req_queue2.sv
// Two-entry val/rdy queue with wrapping 1-bit pointers; output comes straight
// from the head entry, so there is no enqueue-to-dequeue bypass.
module plab5_mcore_req_queue2 #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);
    logic       head_reg;
    logic       tail_reg;
    logic [1:0] count_reg;
    logic       enq_fire;
    logic       deq_fire;
    logic [p_nbits-1:0] entry [2];

    assign enq_rdy  = (count_reg != 2'd2);
    assign deq_val  = (count_reg != 2'd0);
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_msg  = entry[head_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= 1'b0;
            tail_reg  <= 1'b0;
            count_reg <= 2'd0;
        end else begin
            if (enq_fire) tail_reg <= ~tail_reg;
            if (deq_fire) head_reg <= ~head_reg;
            case ({enq_fire, deq_fire})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed while count says valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [p_nbits-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (enq_fire && (tail_reg == 1'(gi))) data_reg <= enq_msg;
            end
            assign entry[gi] = data_reg;
        end
    endgenerate

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_req_buf.sv
// Bank-side receiver: filters network requests by requester domain, buffers
// accepted ones as memory requests and reports rejected ones.
module plab5_mcore_net_msg_to_mem_req_buf
    import plab5_mcore_net_msg_to_mem_req_buf_pkg::*;
#(
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_addr_nbits    = 32,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    parameter int p_bank_domain       = 2
) (
    input logic clk,
    input logic reset,
    plab5_mcore_net_msg_to_mem_req_buf_if.slave bus
);
    localparam int c_mem_msg_cnbits = mem_msg_cnbits(p_mem_opaque_nbits, p_mem_addr_nbits);
    localparam int c_net_msg_cnbits = net_msg_cnbits(p_net_srcdest_nbits, p_net_opaque_nbits,
                                                     p_mem_opaque_nbits, p_mem_addr_nbits);
    localparam int c_q_nbits        = c_mem_msg_cnbits + p_mem_data_nbits + 1;
    localparam int c_mem_opaque_lsb = p_mem_addr_nbits + MEM_REQ_LEN_NBITS;

    logic [c_mem_msg_cnbits-1:0]    mem_ctrl;
    logic [p_net_srcdest_nbits-1:0] src;
    logic                           req_dom;
    logic                           accept;
    logic                           net_req_rdy;
    logic                           net_fire;
    logic                           unused_fields;

    logic                           rej_val_reg;
    logic [7:0]                     rej_count_reg;
    logic [p_net_srcdest_nbits-1:0] rej_src_reg;
    logic [p_mem_opaque_nbits-1:0]  rej_opaque_reg;

    logic                 q_enq_val;
    logic                 q_enq_rdy;
    logic [c_q_nbits-1:0] q_enq_msg;
    logic                 q_deq_val;
    logic [c_q_nbits-1:0] q_deq_msg;

    assign mem_ctrl = bus.net_msg_control[c_mem_msg_cnbits-1:0];
    assign req_dom  = ~bus.net_msg_control[c_mem_msg_cnbits];
    assign src      = bus.net_msg_control[c_net_msg_cnbits-p_net_srcdest_nbits-1 -: p_net_srcdest_nbits];
    assign accept   = domain_accept(p_bank_domain, req_dom);

    // Destination and network opaque are consumed by the network, not by the bank.
    assign unused_fields = ^{bus.net_msg_control[c_net_msg_cnbits-1 -: p_net_srcdest_nbits],
                             bus.net_msg_control[c_mem_msg_cnbits+1 +: p_net_opaque_nbits]};

    // A pending reject stalls all input so requests leave in arrival order.
    assign net_req_rdy     = q_enq_rdy && !rej_val_reg;
    assign net_fire        = bus.net_req_val && net_req_rdy;
    assign bus.net_req_rdy = net_req_rdy;

    assign q_enq_val = net_fire && accept;
    assign q_enq_msg = {mem_ctrl, bus.net_msg_data, req_dom};

    plab5_mcore_req_queue2 #(
        .p_nbits (c_q_nbits)
    ) req_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (q_enq_val),
        .enq_rdy (q_enq_rdy),
        .enq_msg (q_enq_msg),
        .deq_val (q_deq_val),
        .deq_rdy (bus.mem_req_rdy),
        .deq_msg (q_deq_msg)
    );

    assign bus.mem_req_val    = q_deq_val;
    assign bus.mem_req_msg    = q_deq_msg[c_q_nbits-1:1];
    assign bus.mem_req_domain = q_deq_msg[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rej_val_reg   <= 1'b0;
            rej_count_reg <= 8'd0;
        end else if (net_fire && !accept) begin
            rej_val_reg <= 1'b1;
            if (rej_count_reg != 8'hFF) rej_count_reg <= rej_count_reg + 8'd1;
        end else if (rej_val_reg && bus.rej_rdy) begin
            rej_val_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (net_fire && !accept) begin
            rej_src_reg    <= src;
            rej_opaque_reg <= mem_ctrl[c_mem_opaque_lsb +: p_mem_opaque_nbits];
        end
    end

    assign bus.rej_val    = rej_val_reg;
    assign bus.rej_src    = rej_src_reg;
    assign bus.rej_opaque = rej_opaque_reg;
    assign bus.rej_count  = rej_count_reg;

endmodule

// File: tb/tb_plab5_mcore_net_msg_to_mem_req_buf.sv
// Directed bench: one instance accepting both domains, one accepting domain 0 only.
module tb_plab5_mcore_net_msg_to_mem_req_buf;
    import plab5_mcore_net_msg_to_mem_req_buf_pkg::*;

    localparam int MO = 8;
    localparam int MA = 32;
    localparam int MD = 32;
    localparam int NO = 4;
    localparam int NS = 3;
    localparam int NC = 56;
    localparam int MW = 77;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    plab5_mcore_net_msg_to_mem_req_buf_if #(
        .p_mem_opaque_nbits(MO), .p_mem_addr_nbits(MA), .p_mem_data_nbits(MD),
        .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS)
    ) ifa ();
    plab5_mcore_net_msg_to_mem_req_buf_if #(
        .p_mem_opaque_nbits(MO), .p_mem_addr_nbits(MA), .p_mem_data_nbits(MD),
        .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS)
    ) ifb ();

    plab5_mcore_net_msg_to_mem_req_buf #(
        .p_mem_opaque_nbits(MO), .p_mem_addr_nbits(MA), .p_mem_data_nbits(MD),
        .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS), .p_bank_domain(2)
    ) dut_any (.clk(clk), .reset(reset), .bus(ifa.slave));

    plab5_mcore_net_msg_to_mem_req_buf #(
        .p_mem_opaque_nbits(MO), .p_mem_addr_nbits(MA), .p_mem_data_nbits(MD),
        .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS), .p_bank_domain(0)
    ) dut_d0 (.clk(clk), .reset(reset), .bus(ifb.slave));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NC-1:0] mk_ctrl(input logic [2:0] src, input logic dom_n,
                                              input logic [2:0] typ, input logic [7:0] opq,
                                              input logic [31:0] addr);
        return {3'd5, src, 4'hA, dom_n, typ, opq, addr, 2'd0};
    endfunction

    function automatic logic [MW-1:0] mk_msg(input logic [2:0] typ, input logic [7:0] opq,
                                             input logic [31:0] addr, input logic [31:0] data);
        return {typ, opq, addr, 2'd0, data};
    endfunction

    typedef struct {
        logic [2:0]  src;
        logic        dom_n;
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_dom;
        logic        exp_b_rej;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] ctrl;
        logic [MW-1:0] msg;
        logic [MW-1:0] msg_a;
        logic [MW-1:0] msg_b;
        logic [MW-1:0] msg_c;
        int exp_rej_cnt;
        int fires;
        int sat_err;

        ifa.net_req_val = 1'b0; ifa.net_msg_control = '0; ifa.net_msg_data = '0;
        ifa.mem_req_rdy = 1'b0; ifa.rej_rdy = 1'b0;
        ifb.net_req_val = 1'b0; ifb.net_msg_control = '0; ifb.net_msg_data = '0;
        ifb.mem_req_rdy = 1'b0; ifb.rej_rdy = 1'b0;

        vecs[0] = '{3'd1, 1'b0, 3'd0, 8'h25, 32'h0000_4010, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[1] = '{3'd3, 1'b0, 3'd0, 8'h61, 32'h0000_8000, 32'h1234_5678, 1'b1, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 3'd1, 8'h4C, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 1'b0, 1'b0};
        vecs[3] = '{3'd7, 1'b1, 3'd0, 8'hE3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[4] = '{3'd6, 1'b0, 3'd1, 8'hC7, 32'h1234_5670, 32'hFFFF_FFFF, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_mem_val", ifa.mem_req_val, 1'b0);
        chk("rst_b_rej_val", ifb.rej_val, 1'b0);
        chk("rst_b_rej_count", ifb.rej_count, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_a_net_rdy", ifa.net_req_rdy, 1'b1);
        chk("rst_b_net_rdy", ifb.net_req_rdy, 1'b1);
        $display("reset released: a.rdy=%0b b.rdy=%0b", ifa.net_req_rdy, ifb.net_req_rdy);

        // Table: same request to both instances
        exp_rej_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            ctrl = mk_ctrl(vecs[i].src, vecs[i].dom_n, vecs[i].typ, vecs[i].opq, vecs[i].addr);
            msg  = mk_msg(vecs[i].typ, vecs[i].opq, vecs[i].addr, vecs[i].data);
            ifa.net_msg_control = ctrl; ifa.net_msg_data = vecs[i].data; ifa.net_req_val = 1'b1;
            ifb.net_msg_control = ctrl; ifb.net_msg_data = vecs[i].data; ifb.net_req_val = 1'b1;
            @(negedge clk);
            ifa.net_req_val = 1'b0; ifb.net_req_val = 1'b0;
            chk($sformatf("v%0d_a_mem_val", i), ifa.mem_req_val, 1'b1);
            chk($sformatf("v%0d_a_msg", i), ifa.mem_req_msg, msg);
            chk($sformatf("v%0d_a_dom", i), ifa.mem_req_domain, vecs[i].exp_dom);
            chk($sformatf("v%0d_b_mem_val", i), ifb.mem_req_val, !vecs[i].exp_b_rej);
            chk($sformatf("v%0d_b_rej_val", i), ifb.rej_val, vecs[i].exp_b_rej);
            if (vecs[i].exp_b_rej) begin
                exp_rej_cnt++;
                chk($sformatf("v%0d_b_rej_src", i), ifb.rej_src, vecs[i].src);
                chk($sformatf("v%0d_b_rej_opq", i), ifb.rej_opaque, vecs[i].opq);
            end else begin
                chk($sformatf("v%0d_b_msg", i), ifb.mem_req_msg, msg);
            end
            chk($sformatf("v%0d_b_rej_count", i), ifb.rej_count, 8'(exp_rej_cnt));
            @(negedge clk);
            chk($sformatf("v%0d_a_msg_hold", i), ifa.mem_req_msg, msg);
            chk($sformatf("v%0d_b_net_rdy_hold", i), ifb.net_req_rdy, !vecs[i].exp_b_rej);
            chk($sformatf("v%0d_b_rej_hold", i), ifb.rej_val, vecs[i].exp_b_rej);
            ifa.mem_req_rdy = 1'b1; ifb.mem_req_rdy = 1'b1; ifb.rej_rdy = 1'b1;
            @(negedge clk);
            ifa.mem_req_rdy = 1'b0; ifb.mem_req_rdy = 1'b0; ifb.rej_rdy = 1'b0;
            chk($sformatf("v%0d_a_drained", i), ifa.mem_req_val, 1'b0);
            chk($sformatf("v%0d_b_drained", i), ifb.mem_req_val, 1'b0);
            chk($sformatf("v%0d_b_rej_clr", i), ifb.rej_val, 1'b0);
            chk($sformatf("v%0d_b_net_rdy", i), ifb.net_req_rdy, 1'b1);
            $display("vec %0d: src=%0d dom_n=%0b addr=0x%08h -> a.dom=%0b b.rej=%0b b.cnt=%0d",
                     i, vecs[i].src, vecs[i].dom_n, vecs[i].addr, ifa.mem_req_domain,
                     vecs[i].exp_b_rej, ifb.rej_count);
        end

        // Backpressure: A, B, C with memory side stalled
        msg_a = mk_msg(3'd0, 8'h20, 32'h0000_00A0, 32'h0000_000A);
        msg_b = mk_msg(3'd1, 8'h21, 32'h0000_00B0, 32'h0000_000B);
        msg_c = mk_msg(3'd0, 8'h22, 32'h0000_00C0, 32'h0000_000C);
        ifa.net_msg_control = mk_ctrl(3'd1, 1'b0, 3'd0, 8'h20, 32'h0000_00A0);
        ifa.net_msg_data = 32'h0000_000A; ifa.net_req_val = 1'b1;
        @(negedge clk);
        chk("bp_rdy_after_a", ifa.net_req_rdy, 1'b1);
        ifa.net_msg_control = mk_ctrl(3'd1, 1'b0, 3'd1, 8'h21, 32'h0000_00B0);
        ifa.net_msg_data = 32'h0000_000B;
        @(negedge clk);
        chk("bp_rdy_after_b", ifa.net_req_rdy, 1'b0);
        ifa.net_msg_control = mk_ctrl(3'd1, 1'b0, 3'd0, 8'h22, 32'h0000_00C0);
        ifa.net_msg_data = 32'h0000_000C;
        @(negedge clk);
        chk("bp_stall_rdy", ifa.net_req_rdy, 1'b0);
        chk("bp_head_a", ifa.mem_req_msg, msg_a);
        ifa.mem_req_rdy = 1'b1;
        @(negedge clk);
        chk("bp_out_b_val", ifa.mem_req_val, 1'b1);
        chk("bp_out_b", ifa.mem_req_msg, msg_b);
        chk("bp_rdy_count1", ifa.net_req_rdy, 1'b1);
        @(negedge clk);
        ifa.net_req_val = 1'b0;
        chk("bp_out_c_val", ifa.mem_req_val, 1'b1);
        chk("bp_out_c", ifa.mem_req_msg, msg_c);
        @(negedge clk);
        chk("bp_empty", ifa.mem_req_val, 1'b0);
        $display("backpressure: A,B,C drained in order");

        // Streaming: 8 back-to-back requests with memory side always ready
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                chk($sformatf("st%0d_val", i - 1), ifa.mem_req_val, 1'b1);
                chk($sformatf("st%0d_msg", i - 1), ifa.mem_req_msg,
                    mk_msg(3'd0, 8'h30, 32'(i - 1) * 32'h10, 32'h100 + 32'(i - 1)));
                chk($sformatf("st%0d_rdy", i - 1), ifa.net_req_rdy, 1'b1);
                $display("stream out %0d: addr=0x%08h", i - 1, ifa.mem_req_msg[65:34]);
            end
            if (i < 8) begin
                ifa.net_msg_control = mk_ctrl(3'd1, 1'b1, 3'd0, 8'h30, 32'(i) * 32'h10);
                ifa.net_msg_data = 32'h100 + 32'(i);
                ifa.net_req_val = 1'b1;
            end else begin
                ifa.net_req_val = 1'b0;
            end
            @(negedge clk);
        end
        chk("st_empty", ifa.mem_req_val, 1'b0);
        ifa.mem_req_rdy = 1'b0;

        // Saturation: 260 more rejects on the domain-0 instance
        ifb.rej_rdy = 1'b1;
        ifb.net_msg_control = mk_ctrl(3'd4, 1'b0, 3'd0, 8'h80, 32'h0);
        ifb.net_req_val = 1'b1;
        fires = 0;
        sat_err = 0;
        for (int cyc = 0; cyc < 2000 && fires < 260; cyc++) begin
            if (ifb.net_req_rdy) begin
                fires++;
                exp_rej_cnt = (exp_rej_cnt >= 255) ? 255 : exp_rej_cnt + 1;
            end
            @(negedge clk);
            if (ifb.rej_count !== 8'(exp_rej_cnt)) sat_err++;
        end
        ifb.net_req_val = 1'b0;
        chk("sat_fires", fires, 260);
        chk("sat_track_errors", sat_err, 0);
        chk("sat_count", ifb.rej_count, 8'd255);
        chk("sat_no_mem", ifb.mem_req_val, 1'b0);
        @(negedge clk);
        ifb.rej_rdy = 1'b0;
        chk("sat_hold", ifb.rej_count, 8'd255);
        $display("saturation: %0d rejects, rej_count=%0d", fires, ifb.rej_count);

        // Reset mid-operation: A full, B holding a reject
        ifa.net_msg_control = mk_ctrl(3'd2, 1'b1, 3'd0, 8'h40, 32'h0000_0300);
        ifa.net_msg_data = 32'h3; ifa.net_req_val = 1'b1;
        ifb.net_msg_control = mk_ctrl(3'd5, 1'b0, 3'd0, 8'hA5, 32'h0000_0500);
        ifb.net_req_val = 1'b1;
        @(negedge clk);
        ifb.net_req_val = 1'b0;
        ifa.net_msg_control = mk_ctrl(3'd2, 1'b1, 3'd0, 8'h41, 32'h0000_0310);
        @(negedge clk);
        ifa.net_req_val = 1'b0;
        chk("mr_a_full", ifa.net_req_rdy, 1'b0);
        chk("mr_b_rej", ifb.rej_val, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mr_a_mem_val_async", ifa.mem_req_val, 1'b0);
        chk("mr_b_rej_val_async", ifb.rej_val, 1'b0);
        chk("mr_b_rej_count_async", ifb.rej_count, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        ifa.mem_req_rdy = 1'b1;
        @(negedge clk);
        chk("mr_a_rdy", ifa.net_req_rdy, 1'b1);
        chk("mr_b_rdy", ifb.net_req_rdy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mr_no_stale%0d", k), ifa.mem_req_val, 1'b0);
            @(negedge clk);
        end
        ifa.mem_req_rdy = 1'b0;
        ifa.net_msg_control = mk_ctrl(3'd3, 1'b0, 3'd1, 8'h66, 32'h0000_0400);
        ifa.net_msg_data = 32'hCAFE_F00D; ifa.net_req_val = 1'b1;
        @(negedge clk);
        ifa.net_req_val = 1'b0;
        chk("mr_fresh_val", ifa.mem_req_val, 1'b1);
        chk("mr_fresh_msg", ifa.mem_req_msg, mk_msg(3'd1, 8'h66, 32'h0000_0400, 32'hCAFE_F00D));
        $display("reset mid-op: fresh request addr=0x%08h", ifa.mem_req_msg[65:34]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
